branch_pc_unit: RTL and testbench

BRANCH_PC_UNIT -- requirements
Module: branch_pc_unit

---
 rtl/branch_pc_unit.sv | 81 ++++++++
 tb/tb_branch_pc_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/branch_pc_unit.sv
// rtl/branch_pc_unit.sv - fetch PC register with branch/jump/jr redirect and taken-redirect counter
// Next PC priority is jr > jmp > taken branch > pc+4; a stall freezes all state.
module branch_pc_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic [31:0]      id_pc,
   input  logic             br,
   input  logic             cmp_out,
   input  logic [15:0]      imm16,
   input  logic             jmp,
   input  logic [25:0]      instr_index,
   input  logic             jr,
   input  logic [31:0]      rs_val,
   output logic [31:0]      pc,
   output logic [31:0]      link_addr,
   output logic             redirect,
   output logic [CNT_W-1:0] taken_cnt,
   output logic             addr_err
);

   logic [31:0]      pc_q, pc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   logic [31:0] id_pc_plus4;
   logic [31:0] br_tgt;
   logic [31:0] j_tgt;
   logic [31:0] jr_tgt;
   logic        br_taken;

   assign id_pc_plus4 = id_pc + 32'd4;
   assign br_tgt      = id_pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
   assign j_tgt       = {id_pc_plus4[31:28], instr_index, 2'b00};
   assign jr_tgt      = {rs_val[31:2], 2'b00};
   assign br_taken    = br & cmp_out;

   assign redirect  = ~stall & (jr | jmp | br_taken);
   assign link_addr = id_pc + 32'd8;

   always_comb begin
      pc_d  = pc_q;
      cnt_d = cnt_q;
      err_d = err_q;
      if (!stall) begin
         if (jr)
            pc_d = jr_tgt;
         else if (jmp)
            pc_d = j_tgt;
         else if (br_taken)
            pc_d = br_tgt;
         else
            pc_d = pc_q + 32'd4;
         // Saturate rather than wrap so software can tell the count overflowed.
         if (redirect && !(&cnt_q))
            cnt_d = cnt_q + 1'b1;
         if (jr && (rs_val[1:0] != 2'b00))
            err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q  <= RESET_PC;
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign pc        = pc_q;
   assign taken_cnt = cnt_q;
   assign addr_err  = err_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// tb/tb_branch_pc_unit.sv - directed and randomized bench for branch_pc_unit
module tb_branch_pc_unit;

   logic        clk = 1'b0;
   logic        reset, stall, br, cmp_out, jmp, jr;
   logic [31:0] id_pc, rs_val;
   logic [15:0] imm16;
   logic [25:0] instr_index;
   logic [31:0] pc, link_addr;
   logic        redirect, addr_err;
   logic [15:0] taken_cnt;

   int          vectors = 0;
   int          miscompares = 0;

   logic [31:0] m_pc;
   int          m_cnt;
   logic        m_err;

   branch_pc_unit #(.RESET_PC(32'h0000_3000), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .stall(stall), .id_pc(id_pc), .br(br),
      .cmp_out(cmp_out), .imm16(imm16), .jmp(jmp), .instr_index(instr_index),
      .jr(jr), .rs_val(rs_val), .pc(pc), .link_addr(link_addr),
      .redirect(redirect), .taken_cnt(taken_cnt), .addr_err(addr_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      stall = 0; br = 0; cmp_out = 0; jmp = 0; jr = 0;
      id_pc = 32'h0000_3000; rs_val = 0; imm16 = 0; instr_index = 0;
   endtask

   function automatic logic model_redirect();
      return !stall && (jr || jmp || (br && cmp_out));
   endfunction

   // Reference next-PC written from the architectural rules with plain arithmetic.
   function automatic logic [31:0] model_next_pc();
      int signed off;
      off = $signed(imm16);
      if (jr)                return rs_val & 32'hFFFF_FFFC;
      else if (jmp)          return ((id_pc + 32'd4) & 32'hF000_0000) | (32'(instr_index) * 4);
      else if (br && cmp_out) return id_pc + 32'd4 + 32'(off * 4);
      else                   return m_pc + 32'd4;
   endfunction

   task automatic model_edge();
      if (!stall) begin
         if (model_redirect() && m_cnt < 65535) m_cnt++;
         if (jr && rs_val[1:0] != 0) m_err = 1'b1;
         m_pc = model_next_pc();
      end
   endtask

   task automatic check_regs(input string tag);
      check({tag, ".pc"}, pc, m_pc);
      check({tag, ".cnt"}, {16'h0, taken_cnt}, 32'(m_cnt));
      check({tag, ".err"}, {31'h0, addr_err}, {31'h0, m_err});
   endtask

   // Inputs are already driven; check combinational outputs, clock once, check registers.
   task automatic step(input string tag);
      #1;
      check({tag, ".redirect"}, {31'h0, redirect}, {31'h0, model_redirect()});
      check({tag, ".link"}, link_addr, id_pc + 32'd8);
      @(posedge clk);
      model_edge();
      #1;
      check_regs(tag);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      m_pc = 32'h0000_3000; m_cnt = 0; m_err = 1'b0;
      #2;
      check_regs("rst_async");
      @(posedge clk);
      #1;
      check_regs("rst_hold");
      reset = 1'b0;
   endtask

   initial begin
      idle_inputs();
      reset = 1'b0;
      @(posedge clk);
      #1;
      do_reset();

      // Sequential fetch after reset
      check("seq0", pc, 32'h3000);
      step("seq1"); check("seq1_abs", pc, 32'h3004);
      step("seq2"); check("seq2_abs", pc, 32'h3008);
      step("seq3"); check("seq3_abs", pc, 32'h300C);

      // Backward taken branch
      id_pc = 32'h3010; br = 1; cmp_out = 1; imm16 = 16'hFFFC;
      step("br_taken");
      check("br_taken_abs", pc, 32'h3004);
      check("br_taken_cnt", {16'h0, taken_cnt}, 32'd1);

      // Not-taken branch falls through
      cmp_out = 0;
      step("br_not_taken");
      check("br_nt_abs", pc, 32'h3008);

      // cmp_out alone has no effect without br
      br = 0; cmp_out = 1;
      step("cmp_no_br");

      // Jump
      cmp_out = 0; id_pc = 32'h3000; jmp = 1; instr_index = 26'h0000C40;
      #1 check("jmp_link_abs", link_addr, 32'h3008);
      step("jmp");
      check("jmp_abs", pc, 32'h3100);
      jmp = 0;

      // Stall blocks jr
      stall = 1; jr = 1; rs_val = 32'h4000;
      step("stall_jr");
      check("stall_pc_abs", pc, 32'h3100);

      // All three requests at once: jr wins, counted once
      stall = 0; jmp = 1; br = 1; cmp_out = 1; imm16 = 16'h0010;
      step("all_three");
      check("all_three_abs", pc, 32'h4000);
      jmp = 0; br = 0; cmp_out = 0;

      // Misaligned jr target sets the sticky error
      rs_val = 32'h4002;
      step("jr_misalign");
      check("jr_mis_abs", pc, 32'h4000);
      check("jr_mis_err_abs", {31'h0, addr_err}, 32'd1);
      idle_inputs();
      for (int i = 0; i < 10; i++) step("err_sticky");

      // Randomized traffic against the reference model
      do_reset();
      for (int i = 0; i < 400; i++) begin
         stall       = ($urandom_range(0, 4) == 0);
         br          = $urandom_range(0, 1);
         cmp_out     = $urandom_range(0, 1);
         jmp         = ($urandom_range(0, 5) == 0);
         jr          = ($urandom_range(0, 7) == 0);
         id_pc       = $urandom & 32'hFFFF_FFFC;
         imm16       = 16'($urandom);
         instr_index = 26'($urandom);
         rs_val      = ($urandom_range(0, 9) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
         step("rand");
      end

      // Counter saturation
      idle_inputs();
      do_reset();
      jmp = 1; instr_index = 26'h0000C40;
      repeat (16'hFFFE) @(posedge clk);
      m_cnt = 16'hFFFE; m_pc = 32'h3100;
      #1;
      check_regs("cnt_preload");
      step("cnt_fffe_plus1");
      step("cnt_fffe_plus2");
      check("cnt_sat_abs", {16'h0, taken_cnt}, 32'h0000_FFFF);
      step("cnt_sat_hold1");
      step("cnt_sat_hold2");

      // Asynchronous reset in the middle of a redirecting cycle
      jr = 1; rs_val = 32'h5003; stall = 0;
      #2;
      reset = 1'b1;
      #1;
      check("async_pc", pc, 32'h3000);
      check("async_cnt", {16'h0, taken_cnt}, 32'd0);
      check("async_err", {31'h0, addr_err}, 32'd0);
      @(posedge clk);
      #1;
      check("async_hold_pc", pc, 32'h3000);
      reset = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
